gray_ptr_sync: RTL and testbench

//   Parametrised multi-flop CDC synchroniser for Gray-coded async-FIFO pointers.

---
 rtl/gray_ptr_sync_if.sv | 33 +++
 rtl/gray_ptr_sync.sv | 100 ++++++++++
 tb/tb_gray_ptr_sync.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/gray_ptr_sync_if.sv
// Pointer/status bundle between a Gray pointer source and its
// destination-domain synchroniser.
interface gray_ptr_sync_if #(
    parameter int PTR_WIDTH = 5
);
    logic [PTR_WIDTH-1:0] ptr_gray;
    logic                 err_clr;
    logic [PTR_WIDTH-1:0] sync_gray;
    logic [PTR_WIDTH-1:0] sync_bin;
    logic                 ptr_changed;
    logic                 gray_err;
    logic                 sync_valid;

    modport master (
        output ptr_gray,
        output err_clr,
        input  sync_gray,
        input  sync_bin,
        input  ptr_changed,
        input  gray_err,
        input  sync_valid
    );

    modport slave (
        input  ptr_gray,
        input  err_clr,
        output sync_gray,
        output sync_bin,
        output ptr_changed,
        output gray_err,
        output sync_valid
    );
endinterface

// File: rtl/gray_ptr_sync.sv
// Multi-flop Gray pointer synchroniser with binary output,
// change pulse, sticky protocol-error flag and warm-up valid.
module gray_ptr_sync #(
    parameter int PTR_WIDTH  = 5,
    parameter int NUM_STAGES = 2
) (
    input logic            CLK,
    input logic            RST,
    gray_ptr_sync_if.slave bus
);
    localparam int CW = $clog2(NUM_STAGES + 2);

    typedef logic [PTR_WIDTH-1:0] ptr_t;
    typedef enum logic {WARMUP, ACTIVE} state_e;

    ptr_t          stage_q [NUM_STAGES];
    ptr_t          stage_d [NUM_STAGES];
    ptr_t          sync_gray_q, sync_gray_d;
    ptr_t          sync_bin_q, sync_bin_d;
    logic          ptr_changed_q, ptr_changed_d;
    logic          gray_err_q, gray_err_d;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    ptr_t last;
    ptr_t diff;
    logic valid;
    logic multi;

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
        for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    always_comb begin
        last  = stage_q[NUM_STAGES-1];
        valid = (state_q == ACTIVE);
        diff  = last ^ sync_gray_q;
        // clearing the lowest set bit leaves something iff >1 bit set
        multi = |(diff & (diff - ptr_t'(1)));

        stage_d[0] = bus.ptr_gray;
        for (int k = 1; k < NUM_STAGES; k++) begin
            stage_d[k] = stage_q[k-1];
        end

        sync_gray_d   = last;
        sync_bin_d    = gray2bin(last);
        ptr_changed_d = valid & (diff != '0);
        gray_err_d    = (valid & multi)
                      | (gray_err_q & ~bus.err_clr);

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WARMUP: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_d == CW'(NUM_STAGES + 1)) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = WARMUP;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stage_q       <= '{default: '0};
            sync_gray_q   <= '0;
            sync_bin_q    <= '0;
            ptr_changed_q <= 1'b0;
            gray_err_q    <= 1'b0;
            state_q       <= WARMUP;
            cnt_q         <= '0;
        end else begin
            stage_q       <= stage_d;
            sync_gray_q   <= sync_gray_d;
            sync_bin_q    <= sync_bin_d;
            ptr_changed_q <= ptr_changed_d;
            gray_err_q    <= gray_err_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.sync_gray   = sync_gray_q;
    assign bus.sync_bin    = sync_bin_q;
    assign bus.ptr_changed = ptr_changed_q;
    assign bus.gray_err    = gray_err_q;
    assign bus.sync_valid  = (state_q == ACTIVE);
endmodule

// File: tb/tb_gray_ptr_sync.sv
// Randomised bench for gray_ptr_sync, two depths (2 and 3 stages)
// driven in parallel and checked against a sample-history model.
module tb_gray_ptr_sync;
    localparam int W = 5;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    gray_ptr_sync_if #(.PTR_WIDTH(W)) if2 ();
    gray_ptr_sync_if #(.PTR_WIDTH(W)) if3 ();

    gray_ptr_sync #(.PTR_WIDTH(W), .NUM_STAGES(2)) dut2 (
        .CLK (CLK),
        .RST (RST),
        .bus (if2.slave)
    );

    gray_ptr_sync #(.PTR_WIDTH(W), .NUM_STAGES(3)) dut3 (
        .CLK (CLK),
        .RST (RST),
        .bus (if3.slave)
    );

    int passed = 0;
    int total  = 0;

    logic [W-1:0] hist [$];
    logic [W-1:0] cur_p;
    int           k;
    logic [W-1:0] m_sg  [2];
    bit           m_val [2];
    bit           m_chg [2];
    bit           m_err [2];

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t",
                      tag, got, exp, $time);
    endtask

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b = '0;
        for (int s = 0; s < W; s++) b ^= g >> s;
        return b;
    endfunction

    function automatic logic [W-1:0] b2g(input int b);
        logic [W-1:0] v = W'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic int ones(input logic [W-1:0] v);
        int n = 0;
        for (int s = 0; s < W; s++) n += int'(v[s]);
        return n;
    endfunction

    task automatic model_reset();
        hist.delete();
        k = 0;
        for (int i = 0; i < 2; i++) begin
            m_sg[i]  = '0;
            m_val[i] = 1'b0;
            m_chg[i] = 1'b0;
            m_err[i] = 1'b0;
        end
    endtask

    // one rising edge: output is the value sampled NS edges earlier
    task automatic model_edge(input bit clr);
        logic [W-1:0] nsg;
        int ns;
        k++;
        hist.push_back(cur_p);
        for (int i = 0; i < 2; i++) begin
            ns  = i + 2;
            nsg = (k > ns) ? hist[k-ns-1] : '0;
            m_chg[i] = m_val[i] && (nsg != m_sg[i]);
            m_err[i] = (m_err[i] && !clr)
                    || (m_val[i] && ones(nsg ^ m_sg[i]) > 1);
            m_sg[i]  = nsg;
            m_val[i] = (k >= ns + 1);
        end
    endtask

    task automatic check_all();
        chk("s2 gray",  32'(if2.sync_gray),   32'(m_sg[0]));
        chk("s2 bin",   32'(if2.sync_bin),    32'(g2b(m_sg[0])));
        chk("s2 chg",   32'(if2.ptr_changed), 32'(m_chg[0]));
        chk("s2 err",   32'(if2.gray_err),    32'(m_err[0]));
        chk("s2 valid", 32'(if2.sync_valid),  32'(m_val[0]));
        chk("s3 gray",  32'(if3.sync_gray),   32'(m_sg[1]));
        chk("s3 bin",   32'(if3.sync_bin),    32'(g2b(m_sg[1])));
        chk("s3 chg",   32'(if3.ptr_changed), 32'(m_chg[1]));
        chk("s3 err",   32'(if3.gray_err),    32'(m_err[1]));
        chk("s3 valid", 32'(if3.sync_valid),  32'(m_val[1]));
    endtask

    task automatic drive(input logic [W-1:0] p, input bit c);
        cur_p = p;
        if2.ptr_gray = p;
        if3.ptr_gray = p;
        if2.err_clr  = c;
        if3.err_clr  = c;
    endtask

    task automatic cycle(input logic [W-1:0] p, input bit c);
        drive(p, c);
        @(posedge CLK);
        model_edge(c);
        @(negedge CLK);
        check_all();
    endtask

    // called just after a negedge; returns at a negedge with RST high
    task automatic do_reset(input logic [W-1:0] p, input int hold);
        RST = 1'b0;
        drive(p, 1'b0);
        model_reset();
        #1;
        check_all();
        repeat (hold) @(posedge CLK);
        @(negedge CLK);
        check_all();
        RST = 1'b1;
    endtask

    initial begin
        int b;
        logic [W-1:0] p;
        bit c;
        drive('0, 1'b0);
        model_reset();
        @(negedge CLK);
        do_reset('0, 2);

        repeat (6) cycle('0, 1'b0);
        cycle(5'b00001, 1'b0);
        repeat (4) cycle(5'b00001, 1'b0);

        for (int n = 2; n <= 40; n++) cycle(b2g(n % 32), 1'b0);

        repeat (4) cycle('0, 1'b0);
        repeat (5) cycle(5'b00011, 1'b0);
        cycle(5'b00011, 1'b1);
        repeat (2) cycle(5'b00011, 1'b0);
        repeat (6) cycle('0, 1'b1);
        repeat (3) cycle('0, 1'b0);
        cycle('0, 1'b1);
        cycle('0, 1'b0);

        b = 0;
        for (int n = 0; n < 400; n++) begin
            c = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 99) == 0) begin
                p = W'($urandom);
                do_reset(p, $urandom_range(1, 3));
                b = int'(g2b(p));
            end else if ($urandom_range(0, 9) == 0) begin
                p = W'($urandom);
                b = int'(g2b(p));
                cycle(p, c);
            end else begin
                b = (b + $urandom_range(0, 1)) % 32;
                cycle(b2g(b), c);
            end
        end

        do_reset(5'b10101, 2);
        repeat (8) cycle(5'b10101, 1'b0);
        chk("hold bin s2", 32'(if2.sync_bin), 32'd25);
        chk("hold bin s3", 32'(if3.sync_bin), 32'd25);

        cycle(5'b10101, 1'b0);
        RST = 1'b0;
        #1;
        chk("async rst valid", 32'(if3.sync_valid), 32'd0);
        chk("async rst gray",  32'(if2.sync_gray),  32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
